// File: rtl/ssd_display_driver.sv
// Four-digit common-anode seven-segment driver: converts a 13-bit binary value
// to BCD with a sequential double-dabble engine and scans the digits out.
module ssd_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        DatapathClk,
  input  logic        rst,
  input  logic [12:0] SSDInput,
  output logic [3:0]  Anode,
  output logic [6:0]  LED_out,
  output logic        busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t            state_q, state_d;
  logic [12:0]       last_q, last_d;
  logic [15:0]       disp_q, disp_d;
  logic [12:0]       shift_q, shift_d;
  logic [15:0]       work_q, work_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        sel_q;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        led_q, led_d;
  logic [15:0]       work_adj;
  logic [28:0]       shifted;

  assign work_adj = bcd_adjust(work_q);
  assign shifted  = {work_adj, shift_q} << 1;

  // Control state: conversion FSM, captured value and committed BCD.
  always_ff @(posedge DatapathClk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      disp_q  <= disp_d;
    end
  end

  // Working registers are always loaded on capture, so they carry no reset.
  always_ff @(posedge DatapathClk) begin
    shift_q  <= shift_d;
    work_q   <= work_d;
    bitcnt_q <= bitcnt_d;
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    disp_d   = disp_q;
    shift_d  = shift_q;
    work_d   = work_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      IDLE: begin
        if (SSDInput != last_q) begin
          shift_d  = SSDInput;
          last_d   = SSDInput;
          work_d   = '0;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = shifted[28:13];
        shift_d = shifted[12:0];
        if (bitcnt_q == 4'd12) state_d = LOAD;
        else                   bitcnt_d = bitcnt_q + 4'd1;
      end
      LOAD: begin
        disp_d  = work_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Scan: a digit is a leading zero when it and all higher digits are zero.
  always_comb begin
    logic [3:0] dig;
    logic       lz;
    dig = disp_q[3:0];
    lz  = 1'b0;
    case (sel_q)
      2'd0: begin dig = disp_q[3:0];   lz = 1'b0;                  end
      2'd1: begin dig = disp_q[7:4];   lz = (disp_q[15:4] == '0);  end
      2'd2: begin dig = disp_q[11:8];  lz = (disp_q[15:8] == '0);  end
      default: begin dig = disp_q[15:12]; lz = (disp_q[15:12] == '0); end
    endcase
    anode_d = ~(4'b0001 << sel_q);
    led_d   = (BLANK_LZ && lz) ? 7'b1111111 : seg7(dig);
  end

  always_ff @(posedge DatapathClk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      anode_q <= 4'b1111;
      led_q   <= 7'b1111111;
    end else begin
      anode_q <= anode_d;
      led_q   <= led_d;
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        sel_q <= sel_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign Anode   = anode_q;
  assign LED_out = led_q;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Directed bench for ssd_display_driver with a fast scan; a second instance
// with leading-zero blanking disabled shares the same stimulus.
module tb_ssd_display_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] val;
  logic [3:0]  an_b, an_n;
  logic [6:0]  led_b, led_n;
  logic        busy_b, busy_n;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  ssd_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .DatapathClk(clk), .rst(rst_n), .SSDInput(val),
    .Anode(an_b), .LED_out(led_b), .busy(busy_b));

  ssd_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .DatapathClk(clk), .rst(rst_n), .SSDInput(val),
    .Anode(an_n), .LED_out(led_n), .busy(busy_n));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected blanked-instance segments for value v on whichever digit an selects.
  function automatic logic [6:0] model_led(input int v, input logic [3:0] an);
    int k;
    int p;
    k = 0;
    case (an)
      4'b1110: k = 0;
      4'b1101: k = 1;
      4'b1011: k = 2;
      4'b0111: k = 3;
      default: return 7'bxxxxxxx;
    endcase
    p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    if (k > 0 && v < p) return 7'b1111111;
    return seg_ref((v / p) % 10);
  endfunction

  task automatic wait_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_b) cnt++;
      else if (cnt > 0) break;
    end
  endtask

  // exp packs {digit3, digit2, digit1, digit0}.
  task automatic show(input string tag, input logic [27:0] exp, input bit nb);
    bit ok;
    logic [3:0] an;
    for (int k = 0; k < 4; k++) begin
      an = ~(4'b0001 << k);
      ok = 1'b0;
      for (int i = 0; i < 24; i++) begin
        if (an_b === an) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      check($sformatf("%s_an%0d_seen", tag, k), {15'b0, ok}, 16'd1);
      check($sformatf("%s_d%0d", tag, k), {9'b0, (nb ? led_n : led_b)}, {9'b0, exp[k*7 +: 7]});
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    val   = 13'd0;
    repeat (3) @(negedge clk);
    check("rst_anode", {12'b0, an_b}, 16'h000F);
    check("rst_led", {9'b0, led_b}, {9'b0, 7'b1111111});
    check("rst_busy", {15'b0, busy_b}, 16'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("scan_an_%0d", i), {12'b0, an_b}, {12'b0, ~(4'b0001 << (i / 4))});
      check($sformatf("scan_led_%0d", i), {9'b0, led_b},
            {9'b0, (i < 4) ? 7'b0000001 : 7'b1111111});
      check($sformatf("scan_nb_%0d", i), {9'b0, led_n}, {9'b0, 7'b0000001});
    end

    val = 13'd1234;
    check("idle_busy", {15'b0, busy_b}, 16'd0);
    wait_busy(n);
    check("busy_len_1234", 16'(n), 16'd14);
    @(negedge clk);
    show("v1234", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 1'b0);

    val = 13'd8191;
    wait_busy(n);
    @(negedge clk);
    show("v8191", {7'b0000000, 7'b1001111, 7'b0000100, 7'b1001111}, 1'b0);

    val = 13'd7;
    wait_busy(n);
    @(negedge clk);
    show("v7_blank", {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}, 1'b0);
    show("v7_noblank", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111}, 1'b1);

    val = 13'd1005;
    wait_busy(n);
    @(negedge clk);
    show("v1005", {7'b1001111, 7'b0000001, 7'b0000001, 7'b0100100}, 1'b0);

    val = 13'd1234;
    repeat (5) @(negedge clk);
    check("chg_busy_mid", {15'b0, busy_b}, 16'd1);
    val = 13'd42;
    wait_busy(n);
    check("chg_busy_rest", 16'(n), 16'd9);
    @(negedge clk);
    check("chg_reconvert_busy", {15'b0, busy_b}, 16'd1);
    check("chg_commit_1234", {9'b0, led_b}, {9'b0, model_led(1234, an_b)});
    wait_busy(n);
    check("chg_busy_second", 16'(n), 16'd13);
    @(negedge clk);
    show("v42", {7'b1111111, 7'b1111111, 7'b1001100, 7'b0010010}, 1'b0);

    val = 13'd999;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_anode", {12'b0, an_b}, 16'h000F);
    check("midrst_led", {9'b0, led_b}, {9'b0, 7'b1111111});
    check("midrst_busy", {15'b0, busy_b}, 16'd0);
    @(negedge clk);
    check("midrst_hold_anode", {12'b0, an_b}, 16'h000F);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_anode", {12'b0, an_b}, 16'h000E);
    check("post_rst_led", {9'b0, led_b}, {9'b0, 7'b0000001});
    check("post_rst_busy", {15'b0, busy_b}, 16'd1);
    wait_busy(n);
    check("post_rst_busy_len", 16'(n), 16'd13);
    @(negedge clk);
    show("v999", {7'b1111111, 7'b0000100, 7'b0000100, 7'b0000100}, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
